// File: rtl/uart_pkg.sv
// Shared UART types and sizing, used by the receiver and the transmitter blocks.
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int UART_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_st_t;

endpackage

// File: rtl/uart_sync2.sv
// Flop-chain synchronizer for an asynchronous single-bit input, with a selectable reset value.
module uart_sync2
  import uart_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [UART_SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= {UART_SYNC_STAGES{RST_VAL}};
    end else begin
      ff <= {ff[UART_SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff[UART_SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: start, 8 data bits MSB-first, optional even parity, stop; one-cycle byte strobe.
// Define UART_RX_PARITY_EN to include the parity bit; otherwise frames are start+8+stop and rx_perr is 0.
//
// state  | meaning
// IDLE   | line idle, waiting for a low level
// START  | start bit seen, re-check at half a bit to reject glitches
// DATA   | sampling 8 data bits at bit centres
// PARITY | sampling the even-parity bit
// STOP   | sampling the stop bit, byte delivered on the next cycle
// BREAK  | stop bit was low, waiting for the line to return high
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_rx,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_vld,
  output logic                   rx_perr,
  output logic                   rx_ferr,
  output logic                   rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(UART_DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_W - 1);

  logic                   rxs;
  uart_rx_st_t            state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [BIT_W-1:0]       bit_cnt, bit_cnt_nxt;
  logic [UART_DATA_W-1:0] shift, shift_nxt;
  logic [UART_DATA_W-1:0] rx_data_nxt;
  logic                   rx_vld_nxt, rx_perr_nxt, rx_ferr_nxt;
  logic                   bit_tick;
`ifdef UART_RX_PARITY_EN
  logic                   perr_q, perr_nxt;
`endif

  uart_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (uart_rx),
    .q  (rxs)
  );

  assign bit_tick = (cnt == CNT_LAST);
  assign rx_busy  = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = bit_tick ? '0 : cnt + CNT_W'(1);
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    rx_data_nxt = rx_data;
    rx_vld_nxt  = 1'b0;
    rx_perr_nxt = rx_perr;
    rx_ferr_nxt = rx_ferr;
`ifdef UART_RX_PARITY_EN
    perr_nxt    = perr_q;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rxs) begin
          state_nxt   = START;
          bit_cnt_nxt = '0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          state_nxt = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_nxt   = {shift[UART_DATA_W-2:0], rxs};
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          perr_nxt  = rxs ^ (^shift);
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          // Byte is delivered even on a framing error; the flags tell the decoder.
          rx_vld_nxt  = 1'b1;
          rx_data_nxt = shift;
          rx_ferr_nxt = ~rxs;
`ifdef UART_RX_PARITY_EN
          rx_perr_nxt = perr_q;
`else
          rx_perr_nxt = 1'b0;
`endif
          state_nxt   = rxs ? IDLE : BREAK;
        end
      end
      BREAK: begin
        cnt_nxt = '0;
        if (rxs) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      rx_data <= '0;
      rx_vld  <= 1'b0;
      rx_perr <= 1'b0;
      rx_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
      rx_data <= rx_data_nxt;
      rx_vld  <= rx_vld_nxt;
      rx_perr <= rx_perr_nxt;
      rx_ferr <= rx_ferr_nxt;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame at 16 clocks per bit; adapts frame length to UART_RX_PARITY_EN.
module tb_uart_rx_frame;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int BT    = 16;
  localparam int NBITS = PAR_EN ? 11 : 10;
  localparam int FRAME = NBITS * BT;
  localparam int LAT   = 2 + BT / 2 + (NBITS - 1) * BT + 1;
  localparam int OBS_MAX = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_vld, rx_perr, rx_ferr, rx_busy;

  uart_rx_frame #(
    .CLKS_PER_BIT(BT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .uart_rx(uart_rx),
    .rx_data(rx_data),
    .rx_vld (rx_vld),
    .rx_perr(rx_perr),
    .rx_ferr(rx_ferr),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder: written only here, read by the test.
  logic [7:0] obs_data [OBS_MAX];
  bit         obs_perr [OBS_MAX];
  bit         obs_ferr [OBS_MAX];
  int         obs_cyc  [OBS_MAX];
  int         obs_n   = 0;
  int         dbl_vld = 0;
  bit         prev_vld = 1'b0;

  always @(negedge clk) begin
    if (rx_vld) begin
      if (obs_n < OBS_MAX) begin
        obs_data[obs_n] <= rx_data;
        obs_perr[obs_n] <= rx_perr;
        obs_ferr[obs_n] <= rx_ferr;
        obs_cyc[obs_n]  <= cyc;
      end
      obs_n <= obs_n + 1;
      if (prev_vld) dbl_vld <= dbl_vld + 1;
    end
    prev_vld <= rx_vld;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Caller is positioned on a negedge; returns on a negedge.
  task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop,
                            input int idle, output int t0);
    t0 = cyc;
    uart_rx = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      uart_rx = d[i];
      repeat (BT) @(negedge clk);
    end
    if (PAR_EN) begin
      uart_rx = (^d) ^ flip;
      repeat (BT) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BT) @(negedge clk);
    uart_rx = 1'b1;
    repeat (idle) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         flip;
    bit         stop;
    logic [7:0] e_data;
    bit         e_perr;
    bit         e_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    bit         perr;
    bit         ferr;
    int         at;
  } exp_t;

  vec_t tbl [7];
  exp_t exp_q [$];

  initial begin
    int   t0, tr, base;
    bit   seen_busy;
    logic [7:0] r_data;
    logic r_vld, r_perr, r_ferr, r_busy;

    tbl[0] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b0,   1'b0};
    tbl[1] = '{8'h45, 1'b1, 1'b1, 8'h45, PAR_EN, 1'b0};
    tbl[2] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0,   1'b0};
    tbl[3] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0,   1'b0};
    tbl[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, PAR_EN, 1'b0};
    tbl[5] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0,   1'b1};
    tbl[6] = '{8'h80, 1'b1, 1'b0, 8'h80, PAR_EN, 1'b1};

    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset rx_data", rx_data, 8'h00);
    chk("reset rx_vld",  rx_vld,  1'b0);
    chk("reset rx_perr", rx_perr, 1'b0);
    chk("reset rx_ferr", rx_ferr, 1'b0);
    chk("reset rx_busy", rx_busy, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      base = obs_n;
      send_frame(tbl[i].d, tbl[i].flip, tbl[i].stop, 20, t0);
      chk($sformatf("vec%0d count", i), obs_n - base, 1);
      chk($sformatf("vec%0d data", i), obs_data[base], tbl[i].e_data);
      chk($sformatf("vec%0d perr", i), obs_perr[base], tbl[i].e_perr);
      chk($sformatf("vec%0d ferr", i), obs_ferr[base], tbl[i].e_ferr);
      chk($sformatf("vec%0d latency", i), obs_cyc[base] - t0, LAT);
    end

    base = obs_n;
    send_frame(8'h23, 1'b0, 1'b1, 0, t0);
    send_frame(8'h45, 1'b0, 1'b1, 0, tr);
    send_frame(8'h89, 1'b0, 1'b1, 20, tr);
    chk("b2b count", obs_n - base, 3);
    chk("b2b data0", obs_data[base],     8'h23);
    chk("b2b data1", obs_data[base + 1], 8'h45);
    chk("b2b data2", obs_data[base + 2], 8'h89);
    chk("b2b flags", {obs_perr[base], obs_ferr[base], obs_perr[base + 1],
                      obs_ferr[base + 1], obs_perr[base + 2], obs_ferr[base + 2]}, 0);
    chk("b2b first latency", obs_cyc[base] - t0, LAT);
    chk("b2b spacing01", obs_cyc[base + 1] - obs_cyc[base], FRAME);
    chk("b2b spacing12", obs_cyc[base + 2] - obs_cyc[base + 1], FRAME);

    base = obs_n;
    send_frame(8'h89, 1'b0, 1'b0, 0, t0);
    uart_rx = 1'b0;
    repeat (40 * BT) @(negedge clk);
    chk("break count", obs_n - base, 1);
    chk("break data", obs_data[base], 8'h89);
    chk("break ferr", obs_ferr[base], 1'b1);
    chk("break perr", obs_perr[base], 1'b0);
    chk("break busy held", rx_busy, 1'b1);
    uart_rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("break release busy", rx_busy, 1'b0);
    chk("break release count", obs_n - base, 1);
    send_frame(8'h01, 1'b0, 1'b1, 20, t0);
    chk("after break count", obs_n - base, 2);
    chk("after break data", obs_data[base + 1], 8'h01);
    chk("after break flags", {obs_perr[base + 1], obs_ferr[base + 1]}, 2'b00);

    base = obs_n;
    r_data = 8'hxx; r_vld = 1'bx; r_perr = 1'bx; r_ferr = 1'bx; r_busy = 1'bx;
    fork
      send_frame(8'h1F, 1'b0, 1'b1, 40, t0);
      begin
        repeat (4 * BT + 8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        r_data = rx_data; r_vld = rx_vld; r_perr = rx_perr; r_ferr = rx_ferr; r_busy = rx_busy;
      end
    join
    chk("midrst rx_data", r_data, 8'h00);
    chk("midrst rx_vld",  r_vld,  1'b0);
    chk("midrst rx_perr", r_perr, 1'b0);
    chk("midrst rx_ferr", r_ferr, 1'b0);
    chk("midrst rx_busy", r_busy, 1'b0);
    chk("midrst no strobe", obs_n - base, 0);
    send_frame(8'h23, 1'b0, 1'b1, 20, t0);
    chk("midrst next count", obs_n - base, 1);
    chk("midrst next data", obs_data[base], 8'h23);
    chk("midrst next flags", {obs_perr[base], obs_ferr[base]}, 2'b00);

    base = obs_n;
    seen_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      uart_rx = (i < 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (rx_busy) seen_busy = 1'b1;
    end
    chk("glitch busy pulse", seen_busy, 1'b1);
    chk("glitch busy end", rx_busy, 1'b0);
    chk("glitch no strobe", obs_n - base, 0);
    chk("glitch data held", rx_data, 8'h23);

    base = obs_n;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      bit flip, stop;
      int idle;
      exp_t e;
      d    = 8'($urandom_range(0, 255));
      flip = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 5) != 0);
      idle = stop ? int'($urandom_range(0, 12)) : int'($urandom_range(6, 20));
      send_frame(d, flip, stop, idle, t0);
      e.d    = d;
      e.perr = PAR_EN && flip;
      e.ferr = !stop;
      e.at   = t0 + LAT;
      exp_q.push_back(e);
    end
    repeat (20) @(negedge clk);
    chk("rand count", obs_n - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("rand%0d data", i), obs_data[base + i], exp_q[i].d);
      chk($sformatf("rand%0d perr", i), obs_perr[base + i], exp_q[i].perr);
      chk($sformatf("rand%0d ferr", i), obs_ferr[base + i], exp_q[i].ferr);
      chk($sformatf("rand%0d time", i), obs_cyc[base + i], exp_q[i].at);
    end

    chk("rx_vld consecutive", dbl_vld, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Synthesizable UART receiver for the host serial link; the counterpart of the bench-side transmitter model. Deserializes frames of the form idle-high, start 0, data MSB-first (bit7..bit0), even-parity bit (XOR of data), stop 1. Presents each received byte to the command decoder as a one-cycle strobe with parity and framing status.

## Interface
- CLKS_PER_BIT, default 868: clk cycles per bit period; legal range 4..65535.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- uart_rx  input  1  asynchronous serial line, idle high.
- rx_data  output  8  last received byte; holds until the next rx_vld.
- rx_vld  output  1  one-cycle strobe: rx_data, rx_perr and rx_ferr updated this cycle.
- rx_perr  output  1  parity mismatch on the last frame; held with rx_data.
- rx_ferr  output  1  stop bit sampled 0 on the last frame; held with rx_data.
- rx_busy  output  1  high from start-bit detection until return to IDLE.

## Operation
- uart_rx passes through a 2-FF synchronizer (reset value 1); all decisions use the synchronized signal rxs.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: rxs==0 -> START, bit counter cleared.
- START: at count CLKS_PER_BIT/2-1 (integer division), if rxs==0 -> DATA with counter reset; if rxs==1 -> IDLE (glitch rejected, no strobe).
- DATA: sample rxs every CLKS_PER_BIT cycles (bit centre); shift left so the first data bit lands in bit7. After 8 samples -> PARITY.
- PARITY: one sample; perr = sample XOR (^data) -> STOP.
- STOP: one sample. Next cycle: rx_vld=1, rx_data, rx_perr and rx_ferr loaded. The byte is always delivered, even with errors. Sample 1 -> IDLE; sample 0 -> BREAK.
- BREAK: wait for rxs==1, then -> IDLE. No strobes while the line is held low.
- Next start is accepted from the first IDLE cycle, which falls in the second half of the stop bit. Back-to-back frames with no idle time are supported.
- Reset mid-frame: the next cycle is IDLE, shift data is discarded, outputs take reset values, no strobe.
- Reset values: rx_data=8'h00, rx_vld=0, rx_perr=0, rx_ferr=0, rx_busy=0; synchronizer FFs=1.
- Counter width: $clog2(CLKS_PER_BIT). It wraps to 0 at CLKS_PER_BIT-1.

## Timing
- From the uart_rx falling edge: 2 cycles of synchronizer delay, then START.
- rx_vld rises (2 + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT + 1) cycles after the edge with parity enabled. Subtract CLKS_PER_BIT when parity is disabled.
- Jitter of ±1 clk on the edge position is tolerated. Baud mismatch tolerance is ±3% at CLKS_PER_BIT≥16.
- rx_vld is never high on two consecutive cycles.

## Configuration
- UART_RX_PARITY_EN defined: frame includes the parity bit and the PARITY state; rx_perr is computed as above.
- UART_RX_PARITY_EN undefined: the PARITY state is removed, so DATA goes directly to STOP (frame = start+8+stop); rx_perr is tied 0.

## Structure
- Package uart_pkg holds:
  - the state enum uart_rx_st_t (IDLE, START, DATA, PARITY, STOP, BREAK);
  - localparams UART_DATA_W=8 and UART_SYNC_STAGES=2.
- The transmitter block reuses uart_pkg.
- One sub-module: uart_sync2, a 2-FF synchronizer with a reset value parameter.
- The FSM, bit counter and shift register stay in uart_rx_frame.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- Send 0x01 (parity 1, stop 1) -> one rx_vld, rx_data=0x01, rx_perr=0, rx_ferr=0.
- Send 0x23, 0x45, 0x89 back-to-back with zero idle -> three strobes in order with values 0x23, 0x45, 0x89. Each strobe is 176 cycles apart; all flags 0.
- Send 0x45 with parity bit forced 0 -> rx_data=0x45, rx_perr=1, rx_ferr=0.
- Send 0x89 with stop bit 0, then hold the line low for 40 bits -> one strobe with rx_ferr=1, then no further strobes until the line goes high. A following 0x01 is received cleanly.
- Drive a 5-cycle low glitch on idle uart_rx -> no rx_vld; rx_busy pulses then returns to 0; state ends in IDLE.
- Assert rst for 1 cycle during bit4 of a frame -> all outputs at reset values and no strobe for that frame. The next full frame, 0x23, is received correctly.
